// File: rtl/fizzbuzz_classifier_if.sv
`default_nettype none
// ============================================================================
//  Module   : fizzbuzz_classifier_if
//  Purpose  : Operand-in / result-out handshake bundle for fizzbuzz_classifier.
//  Revision : 1.0  initial release
// ============================================================================
interface fizzbuzz_classifier_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_mod3;
  logic [2:0]       out_mod5;
  logic [1:0]       out_class;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_mod3, out_mod5, out_class
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_mod3, out_mod5, out_class
  );
endinterface
`default_nettype wire

// File: rtl/fizzbuzz_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : fizzbuzz_classifier
//  Purpose  : Iterative mod-3 / mod-5 FizzBuzz classifier with per-class counters.
//  Revision : 1.0  initial release
// ============================================================================
module fizzbuzz_classifier #(
  parameter int WIDTH = 8,
  parameter int CW    = 16
) (
  input  wire                  clk,
  input  wire                  rst,
  fizzbuzz_classifier_if.slave bus,
  output logic [CW-1:0]        cnt_num,
  output logic [CW-1:0]        cnt_fizz,
  output logic [CW-1:0]        cnt_buzz,
  output logic [CW-1:0]        cnt_fb,
  output logic                 busy
);

  localparam int              RW      = WIDTH + 3;
  localparam int              KW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0]   C_K_INIT = KW'(WIDTH - 1);
  localparam logic [RW-1:0]   C_THREE  = RW'(3);
  localparam logic [RW-1:0]   C_FIVE   = RW'(5);
  localparam logic [CW-1:0]   C_SAT    = {CW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [RW-1:0]    r_r3;
  logic [RW-1:0]    r_r5;
  logic [KW-1:0]    r_k;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic [CW-1:0]    r_cnt_num;
  logic [CW-1:0]    r_cnt_fizz;
  logic [CW-1:0]    r_cnt_buzz;
  logic [CW-1:0]    r_cnt_fb;

  logic [RW-1:0]    w_sub3;
  logic [RW-1:0]    w_sub5;
  logic [RW-1:0]    w_r3_nxt;
  logic [RW-1:0]    w_r5_nxt;
  logic [1:0]       w_class;
  logic             w_in_hs;
  logic             w_out_hs;

  // One restoring-division step per cycle against 3<<k and 5<<k in parallel.
  always_comb begin
    w_sub3   = C_THREE << r_k;
    w_sub5   = C_FIVE  << r_k;
    w_r3_nxt = (r_r3 >= w_sub3) ? (r_r3 - w_sub3) : r_r3;
    w_r5_nxt = (r_r5 >= w_sub5) ? (r_r5 - w_sub5) : r_r5;
    w_class  = {(r_r5[2:0] == 3'd0), (r_r3[1:0] == 2'd0)};
  end

  assign w_in_hs  = r_in_ready  & bus.in_valid;
  assign w_out_hs = r_out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_data      <= '0;
      r_r3        <= '0;
      r_r5        <= '0;
      r_k         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt_num   <= '0;
      r_cnt_fizz  <= '0;
      r_cnt_buzz  <= '0;
      r_cnt_fb    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_in_hs) begin
            r_data     <= bus.in_data;
            r_r3       <= RW'(bus.in_data);
            r_r5       <= RW'(bus.in_data);
            r_k        <= C_K_INIT;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          r_r3 <= w_r3_nxt;
          r_r5 <= w_r5_nxt;
          if (r_k == '0) begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_k <= r_k - KW'(1);
          end
        end
        S_DONE: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
            case (w_class)
              2'd0:    if (r_cnt_num  != C_SAT) r_cnt_num  <= r_cnt_num  + CW'(1);
              2'd1:    if (r_cnt_fizz != C_SAT) r_cnt_fizz <= r_cnt_fizz + CW'(1);
              2'd2:    if (r_cnt_buzz != C_SAT) r_cnt_buzz <= r_cnt_buzz + CW'(1);
              default: if (r_cnt_fb   != C_SAT) r_cnt_fb   <= r_cnt_fb   + CW'(1);
            endcase
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // Result fields read as zero/NUM whenever no result is being offered.
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_data;
  assign bus.out_mod3  = r_out_valid ? r_r3[1:0] : 2'd0;
  assign bus.out_mod5  = r_out_valid ? r_r5[2:0] : 3'd0;
  assign bus.out_class = r_out_valid ? w_class   : 2'd0;

  assign cnt_num  = r_cnt_num;
  assign cnt_fizz = r_cnt_fizz;
  assign cnt_buzz = r_cnt_buzz;
  assign cnt_fb   = r_cnt_fb;
  assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fizzbuzz_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fizzbuzz_classifier
//  Purpose  : Directed and randomized self-checking bench for fizzbuzz_classifier.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fizzbuzz_classifier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fizzbuzz_classifier_if #(.WIDTH(8)) if_a ();
  fizzbuzz_classifier_if #(.WIDTH(8)) if_b ();

  logic [15:0] a_num, a_fizz, a_buzz, a_fb;
  logic [1:0]  b_num, b_fizz, b_buzz, b_fb;
  logic        a_busy, b_busy;

  fizzbuzz_classifier #(.WIDTH(8), .CW(16)) u_dut_a (
    .clk(clk), .rst(rst), .bus(if_a),
    .cnt_num(a_num), .cnt_fizz(a_fizz), .cnt_buzz(a_buzz), .cnt_fb(a_fb),
    .busy(a_busy)
  );

  fizzbuzz_classifier #(.WIDTH(8), .CW(2)) u_dut_b (
    .clk(clk), .rst(rst), .bus(if_b),
    .cnt_num(b_num), .cnt_fizz(b_fizz), .cnt_buzz(b_buzz), .cnt_fb(b_fb),
    .busy(b_busy)
  );

  function automatic logic [1:0] ref_class(int m3, int m5);
    if (m3 == 0 && m5 == 0) return 2'd3;
    if (m3 == 0)            return 2'd1;
    if (m5 == 0)            return 2'd2;
    return 2'd0;
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    if_a.in_valid = 1'b0;
    if_b.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Issues one operand to DUT A from IDLE; returns edges until out_valid is seen.
  task automatic run_op(input logic [7:0] v, output int lat);
    if_a.in_valid = 1'b1;
    if_a.in_data  = v;
    @(posedge clk);
    @(negedge clk);
    if_a.in_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (if_a.out_valid) break;
    end
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (if_a.in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready: got %0b expected 1", if_a.in_ready); end
    checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b expected 0", if_a.out_valid); end
    checks++; if (a_busy !== 1'b0)         begin errors++; $display("FAIL rst_busy: got %0b expected 0", a_busy); end
    checks++; if (if_a.out_data !== 8'd0)  begin errors++; $display("FAIL rst_out_data: got %0d expected 0", if_a.out_data); end
    checks++; if ({if_a.out_mod3, if_a.out_mod5, if_a.out_class} !== 7'd0)
      begin errors++; $display("FAIL rst_results: got %0d/%0d/%0d expected 0/0/0", if_a.out_mod3, if_a.out_mod5, if_a.out_class); end
    checks++; if ({a_num, a_fizz, a_buzz, a_fb} !== 64'd0)
      begin errors++; $display("FAIL rst_counters: got %0d/%0d/%0d/%0d expected 0/0/0/0", a_num, a_fizz, a_buzz, a_fb); end
    checks++; if ({b_num, b_fizz, b_buzz, b_fb} !== 8'd0 || if_b.in_ready !== 1'b1)
      begin errors++; $display("FAIL rst_dut_b: got cnt %0d/%0d/%0d/%0d rdy %0b expected 0s rdy 1", b_num, b_fizz, b_buzz, b_fb, if_b.in_ready); end
  endtask

  task automatic test_fizzbuzz_15;
    int lat;
    do_reset();
    if_a.out_ready = 1'b1;
    run_op(8'd15, lat);
    checks++; if (lat != 8) begin errors++; $display("FAIL fb15_latency: got %0d expected 8", lat); end
    checks++; if ({if_a.out_mod3, if_a.out_mod5, if_a.out_class} !== {2'd0, 3'd0, 2'd3})
      begin errors++; $display("FAIL fb15_result: got %0d/%0d/%0d expected 0/0/3", if_a.out_mod3, if_a.out_mod5, if_a.out_class); end
    checks++; if (if_a.out_data !== 8'd15 || if_a.in_ready !== 1'b0 || a_busy !== 1'b1)
      begin errors++; $display("FAIL fb15_done_state: got data %0d rdy %0b busy %0b expected 15 0 1", if_a.out_data, if_a.in_ready, a_busy); end
    tick();
    checks++; if (a_fb !== 16'd1 || if_a.in_ready !== 1'b1 || if_a.out_valid !== 1'b0)
      begin errors++; $display("FAIL fb15_after: got fb %0d rdy %0b vld %0b expected 1 1 0", a_fb, if_a.in_ready, if_a.out_valid); end
    checks++; if (if_a.out_class !== 2'd0 || if_a.out_mod5 !== 3'd0)
      begin errors++; $display("FAIL fb15_idle_zero: got class %0d mod5 %0d expected 0 0", if_a.out_class, if_a.out_mod5); end
  endtask

  task automatic test_sequence;
    logic [7:0] vals [4] = '{8'd98, 8'd9, 8'd10, 8'd255};
    logic [1:0] e3   [4] = '{2'd2, 2'd0, 2'd1, 2'd0};
    logic [2:0] e5   [4] = '{3'd3, 3'd4, 3'd0, 3'd0};
    logic [1:0] ec   [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    int lat;
    do_reset();
    if_a.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_op(vals[i], lat);
      checks++; if (lat != 8 || {if_a.out_mod3, if_a.out_mod5, if_a.out_class} !== {e3[i], e5[i], ec[i]})
        begin errors++; $display("FAIL seq_%0d: got lat %0d res %0d/%0d/%0d expected 8 %0d/%0d/%0d", vals[i], lat,
                                 if_a.out_mod3, if_a.out_mod5, if_a.out_class, e3[i], e5[i], ec[i]); end
      tick();
    end
    checks++; if ({a_num, a_fizz, a_buzz, a_fb} !== {16'd1, 16'd1, 16'd1, 16'd1})
      begin errors++; $display("FAIL seq_counters: got %0d/%0d/%0d/%0d expected 1/1/1/1", a_num, a_fizz, a_buzz, a_fb); end
    run_op(8'd0, lat);
    checks++; if ({if_a.out_mod3, if_a.out_mod5, if_a.out_class} !== {2'd0, 3'd0, 2'd3})
      begin errors++; $display("FAIL zero_operand: got %0d/%0d/%0d expected 0/0/3", if_a.out_mod3, if_a.out_mod5, if_a.out_class); end
    tick();
  endtask

  task automatic test_backpressure;
    int lat;
    int bad;
    do_reset();
    if_a.out_ready = 1'b0;
    run_op(8'd7, lat);
    checks++; if (lat != 8) begin errors++; $display("FAIL bp_latency: got %0d expected 8", lat); end
    if_a.in_valid = 1'b1;
    if_a.in_data  = 8'd33;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (if_a.out_valid !== 1'b1 || if_a.in_ready !== 1'b0 || if_a.out_data !== 8'd7 ||
          {if_a.out_mod3, if_a.out_mod5, if_a.out_class} !== {2'd1, 3'd2, 2'd0}) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
    if_a.in_valid  = 1'b0;
    if_a.out_ready = 1'b1;
    tick();
    checks++; if (if_a.out_valid !== 1'b0 || if_a.in_ready !== 1'b1 || a_busy !== 1'b0 || a_num !== 16'd1)
      begin errors++; $display("FAIL bp_release: got vld %0b rdy %0b busy %0b num %0d expected 0 1 0 1",
                               if_a.out_valid, if_a.in_ready, a_busy, a_num); end
  endtask

  task automatic test_reset_midcalc;
    int seen;
    do_reset();
    if_a.out_ready = 1'b1;
    if_a.in_valid  = 1'b1;
    if_a.in_data   = 8'd20;
    tick();
    if_a.in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (if_a.in_ready !== 1'b1 || a_busy !== 1'b0 || if_a.out_valid !== 1'b0)
      begin errors++; $display("FAIL midcalc_reset: got rdy %0b busy %0b vld %0b expected 1 0 0", if_a.in_ready, a_busy, if_a.out_valid); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (if_a.out_valid) seen++;
    end
    checks++; if (seen != 0 || {a_num, a_fizz, a_buzz, a_fb} !== 64'd0)
      begin errors++; $display("FAIL midcalc_no_output: got %0d valid cycles, cnt %0d/%0d/%0d/%0d expected 0 and 0s",
                               seen, a_num, a_fizz, a_buzz, a_fb); end
  endtask

  task automatic test_reset_priority;
    int lat;
    do_reset();
    if_a.out_ready = 1'b1;
    run_op(8'd45, lat);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (a_fb !== 16'd0 || if_a.out_valid !== 1'b0)
      begin errors++; $display("FAIL prio_out_hs: got fb %0d vld %0b expected 0 0", a_fb, if_a.out_valid); end
    rst = 1'b1;
    if_a.in_valid = 1'b1;
    if_a.in_data  = 8'd9;
    tick();
    rst = 1'b0;
    if_a.in_valid = 1'b0;
    checks++; if (a_busy !== 1'b0 || if_a.in_ready !== 1'b1)
      begin errors++; $display("FAIL prio_in_hs: got busy %0b rdy %0b expected 0 1", a_busy, if_a.in_ready); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] vals [4] = '{8'd3, 8'd5, 8'd6, 8'd11};
    logic [1:0] e3   [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
    logic [2:0] e5   [4] = '{3'd3, 3'd0, 3'd1, 3'd1};
    int idx, cyc, last;
    do_reset();
    if_a.out_ready = 1'b1;
    if_a.in_valid  = 1'b1;
    if_a.in_data   = vals[0];
    idx = 0; cyc = 0; last = 0;
    while (idx < 4 && cyc < 200) begin
      tick();
      cyc++;
      if (if_a.out_valid) begin
        checks++; if (if_a.out_data !== vals[idx] || if_a.out_mod3 !== e3[idx] || if_a.out_mod5 !== e5[idx])
          begin errors++; $display("FAIL b2b_result_%0d: got %0d %0d/%0d expected %0d %0d/%0d", idx, if_a.out_data,
                                   if_a.out_mod3, if_a.out_mod5, vals[idx], e3[idx], e5[idx]); end
        if (idx > 0) begin
          checks++; if (cyc - last != 10) begin errors++; $display("FAIL b2b_period_%0d: got %0d expected 10", idx, cyc - last); end
        end
        last = cyc;
        idx++;
        if (idx < 4) if_a.in_data = vals[idx];
        else         if_a.in_valid = 1'b0;
      end
    end
    if_a.in_valid = 1'b0;
    checks++; if (idx != 4) begin errors++; $display("FAIL b2b_count: got %0d results expected 4", idx); end
    tick();
  endtask

  task automatic test_saturation;
    int exp_fb [6] = '{1, 2, 3, 3, 3, 3};
    int n;
    do_reset();
    if_b.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if_b.in_valid = 1'b1;
      if_b.in_data  = 8'd30;
      tick();
      if_b.in_valid = 1'b0;
      n = 0;
      while (!if_b.out_valid && n < 40) begin
        tick();
        n++;
      end
      tick();
      checks++; if (n >= 40 || int'(b_fb) != exp_fb[i])
        begin errors++; $display("FAIL sat_fb_%0d: got %0d (wait %0d) expected %0d", i, b_fb, n, exp_fb[i]); end
    end
    checks++; if ({b_num, b_fizz, b_buzz} !== 6'd0)
      begin errors++; $display("FAIL sat_others: got %0d/%0d/%0d expected 0/0/0", b_num, b_fizz, b_buzz); end
  endtask

  task automatic test_random;
    localparam int N = 30;
    logic [7:0] q [$];
    logic [7:0] v;
    int sent, got, cyc, m3, m5;
    do_reset();
    sent = 0; got = 0; cyc = 0;
    while (got < N && cyc < 4000) begin
      if_a.out_ready = 1'($urandom_range(0, 1));
      if (if_a.out_valid && if_a.out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++; $display("FAIL rand_spurious: got result %0d expected none", if_a.out_data);
        end else begin
          v  = q.pop_front();
          m3 = int'(v) % 3;
          m5 = int'(v) % 5;
          checks++; if (if_a.out_data !== v || int'(if_a.out_mod3) != m3 || int'(if_a.out_mod5) != m5 ||
                        if_a.out_class !== ref_class(m3, m5))
            begin errors++; $display("FAIL rand_result: got %0d %0d/%0d/%0d expected %0d %0d/%0d/%0d", if_a.out_data,
                                     if_a.out_mod3, if_a.out_mod5, if_a.out_class, v, m3, m5, ref_class(m3, m5)); end
        end
        got++;
      end
      if (sent < N && $urandom_range(0, 1) == 1) begin
        if_a.in_valid = 1'b1;
        if_a.in_data  = 8'($urandom_range(4, 100));
      end else begin
        if_a.in_valid = 1'b0;
      end
      if (if_a.in_valid && if_a.in_ready) begin
        q.push_back(if_a.in_data);
        sent++;
      end
      tick();
      cyc++;
    end
    if_a.in_valid  = 1'b0;
    if_a.out_ready = 1'b1;
    checks++; if (got != N || sent != N || q.size() != 0)
      begin errors++; $display("FAIL rand_totals: got %0d results %0d sent %0d pending expected %0d %0d 0", got, sent, q.size(), N, N); end
  endtask

  initial begin
    if_a.in_valid = 1'b0; if_a.in_data = '0; if_a.out_ready = 1'b0;
    if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_fizzbuzz_15();
    test_sequence();
    test_backpressure();
    test_reset_midcalc();
    test_reset_priority();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fizzbuzz_classifier.md
FIZZBUZZ_CLASSIFIER -- requirements
Module: fizzbuzz_classifier

Interface
REQ-001 Parameter WIDTH, default 8, sets the input operand width in bits; legal values are 4 to 16.
REQ-002 Parameter CW, default 16, sets the width of each statistics counter in bits; legal values are 2 to 32.
REQ-003 clk  input  1  single clock; all state updates occur on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  upstream presents an operand.
REQ-006 in_ready  output  1  block can accept an operand.
REQ-007 in_data  input  WIDTH  unsigned operand.
REQ-008 out_valid  output  1  result is available.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 out_data  output  WIDTH  the accepted operand, echoed unchanged.
REQ-011 out_mod3  output  2  operand mod 3.
REQ-012 out_mod5  output  3  operand mod 5.
REQ-013 out_class  output  2  result class: 0=NUM, 1=FIZZ (mod3 only), 2=BUZZ (mod5 only), 3=FIZZBUZZ.
REQ-014 cnt_num, cnt_fizz, cnt_buzz, cnt_fb  output  CW each  per-class counts of completed results.
REQ-015 busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 The block shall implement three states:
- IDLE: in_ready=1.
- CALC: iterating.
- DONE: out_valid=1.
REQ-017 An input handshake occurs on a rising edge where in_valid=1 and in_ready=1. The block shall then:
- latch in_data;
- load both residue registers r3 and r5 with in_data (each WIDTH+3 bits wide);
- set the iteration index k to WIDTH-1;
- enter CALC.
REQ-018 Each CALC cycle shall perform both of these updates in parallel, then decrement k:
- if r3 >= (3<<k), then r3 -= 3<<k;
- if r5 >= (5<<k), then r5 -= 5<<k.
REQ-019 CALC shall last exactly WIDTH cycles, with the final iteration at k=0, then move to DONE. out_valid shall therefore first be high exactly WIDTH clock edges after the accepting edge (8 for the default).
REQ-020 In DONE, the outputs shall be driven as follows:
- out_mod3 = r3[1:0];
- out_mod5 = r5[2:0];
- out_class is derived from (mod3==0, mod5==0);
- out_data = latched operand.
REQ-021 All of out_data, out_mod3, out_mod5 and out_class shall hold stable while out_valid=1 and out_ready=0.
REQ-022 An output handshake (out_valid=1 and out_ready=1 on a rising edge) shall return the block to IDLE and increment exactly one counter, selected by out_class.
REQ-023 Each counter shall saturate at 2^CW-1 and shall not wrap.
REQ-024 in_ready shall be 0 in CALC and in DONE; in_valid in those states shall be ignored and shall not be acknowledged.
REQ-025 in_data=0 shall produce mod3=0, mod5=0 and class FIZZBUZZ.
REQ-026 out_mod3 and out_mod5 shall be driven to 0, and out_class to NUM, whenever out_valid=0.
REQ-027 in_valid asserted on the same edge as an output handshake shall not be accepted. It shall be accepted on the next edge, when in_ready=1 in IDLE, so a back-to-back minimum period is WIDTH+2 cycles per operand.

Reset
REQ-028 When rst=1 at a rising edge, the block shall enter IDLE regardless of state; any in-flight operand shall be discarded without producing an output.
REQ-029 After that reset edge:
- in_ready=1;
- out_valid=0;
- busy=0;
- out_data, r3, r5 and k = 0;
- all four counters = 0.
REQ-030 rst shall take priority over a simultaneous input handshake or output handshake on the same edge.

Verification
REQ-031 Input 15, out_ready=1: out_valid rises 8 cycles after acceptance with mod3=0, mod5=0, class=3, and cnt_fb becomes 1.
REQ-032 Input sequence 98, 9, 10, 255, out_ready=1: results are class 0 (mod 2/3), 1 (mod 0/4), 2 (mod 1/0) and 3 (mod 0/0); each counter ends at 1.
REQ-033 Input 7, out_ready held low for 5 cycles after out_valid rises: out_valid and all result outputs stay stable and in_ready=0 throughout; out_ready=1 then gives IDLE the next cycle and cnt_num=1.
REQ-034 Input 20, then rst pulsed during the 4th CALC cycle: no out_valid ever appears, in_ready=1 after the reset edge, and all counters are 0.
REQ-035 CW=2, six inputs of 30: cnt_fb reads 1, 2, 3, 3, 3, 3 and the other counters stay 0.
REQ-036 Random stimulus over 4..100 with random in_valid and out_ready: each result matches the reference mod 3 and mod 5, and no operand is dropped or duplicated.
